// File: rtl/npc_wb_pkg.sv
// Shared widths and writeback-source encoding for the register-file write front end.
// No logic here.
// Not applicable.
package npc_wb_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef enum logic {
        WB_EXU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (EXU vs LSU) with a last-grant flop.
// Grant is combinational from the requests; the last-grant flop updates on the clock edge.
// The grant doubles as ready, and a grant always completes a handshake, so the arbiter never stalls.
module rr_arb2
    import npc_wb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic reqExu,
    input  logic reqLsu,
    output logic gntExu,
    output logic gntLsu
);

    wb_src_e rrLast;

    // Grant the lone requester; on a tie, grant whichever source did not win last. No grants while in reset.
    always_comb begin
        gntExu = 1'b0;
        gntLsu = 1'b0;
        if (rst) begin
            if (reqExu && reqLsu) begin
                if (rrLast == WB_LSU) begin
                    gntExu = 1'b1;
                end else begin
                    gntLsu = 1'b1;
                end
            end else begin
                gntExu = reqExu;
                gntLsu = reqLsu;
            end
        end
    end

    // Remember the last winner. Reset favours EXU on the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rrLast <= WB_LSU;
        end else if (gntExu) begin
            rrLast <= WB_EXU;
        end else if (gntLsu) begin
            rrLast <= WB_LSU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges EXU/LSU writeback onto the single regfile write port and keeps the per-register busy scoreboard.
// Latency: one cycle from handshake to wb_wen/wb_addr/wb_data; the busy bit clears on the edge that commits the write.
// Producers see ready = grant and the output stage never stalls. Issue stalls (issue_ready=0) while its destination is busy.
module regfile_wb_arbiter
    import npc_wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [AW-1:0]   exu_rd,
    input  logic [XLEN-1:0] exu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic [AW-1:0]   wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_wen,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    logic            gntExu;
    logic            gntLsu;
    logic            wbFire;
    logic [AW-1:0]   winRd;
    logic [XLEN-1:0] winData;
    logic            wbWenQ;
    logic [NREG-1:0] busy;
    logic            issueFire;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .reqExu (exu_valid),
        .reqLsu (lsu_valid),
        .gntExu (gntExu),
        .gntLsu (gntLsu)
    );

    assign exu_ready = gntExu;
    assign lsu_ready = gntLsu;
    assign wbFire    = gntExu | gntLsu;
    assign winRd     = gntExu ? exu_rd   : lsu_rd;
    assign winData   = gntExu ? exu_data : lsu_data;

    // Gate the strobe with reset so a result in flight when reset arrives never reaches the regfile.
    assign wb_wen = wbWenQ & rst;

    // Output register: capture the winning result. A write to x0 is accepted but never strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wbWenQ  <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (wbFire) begin
            wbWenQ  <= (winRd != '0);
            wb_addr <= winRd;
            wb_data <= winData;
        end else begin
            wbWenQ  <= 1'b0;
        end
    end

    // An issue whose destination is already pending is held off, except when that pending write commits this cycle.
    assign issue_ready = rst & ((issue_rd == '0) | !busy[issue_rd] | (wbWenQ & (wb_addr == issue_rd)));
    assign issueFire   = issue_valid & issue_ready;

    // Scoreboard: clear on the committing edge, then set from issue; a set wins over a clear on the same register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            if (wbWenQ && (wb_addr != '0)) begin
                busy[wb_addr] <= 1'b0;
            end
            if (issueFire && (issue_rd != '0)) begin
                busy[issue_rd] <= 1'b1;
            end
        end
    end

    // Hazard queries read the flops directly; a clear becomes visible only the cycle after the write.
    assign rs1_busy = rst & (rs1_addr != '0) & busy[rs1_addr];
    assign rs2_busy = rst & (rs2_addr != '0) & busy[rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are checked before the next edge.
// Every check is an immediate assertion that counts failures.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, lsu_valid, issue_valid;
    logic        exu_ready, lsu_ready, issue_ready;
    logic [4:0]  exu_rd, lsu_rd, issue_rd, rs1_addr, rs2_addr;
    logic [31:0] exu_data, lsu_data;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_wen;
    logic        rs1_busy, rs2_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .exu_valid   (exu_valid),
        .exu_ready   (exu_ready),
        .exu_rd      (exu_rd),
        .exu_data    (exu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_wen      (wb_wen),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        exu_valid = 1'b1; lsu_valid = 1'b1; issue_valid = 1'b1;
        exu_rd = 5'd3; lsu_rd = 5'd4; issue_rd = 5'd5;
        exu_data = 32'h33; lsu_data = 32'h44;
        rs1_addr = 5'd5; rs2_addr = 5'd3;

        // 1: reset held for two cycles with every valid high
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_exu_ready", {31'b0, exu_ready}, 32'd0);
            check("rst_lsu_ready", {31'b0, lsu_ready}, 32'd0);
            check("rst_issue_ready", {31'b0, issue_ready}, 32'd0);
            check("rst_wb_wen", {31'b0, wb_wen}, 32'd0);
            check("rst_rs1_busy", {31'b0, rs1_busy}, 32'd0);
        end
        check("rst_wb_addr", {27'b0, wb_addr}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        exu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("post_rst_busy5", {31'b0, rs1_busy}, 32'd0);
        check("post_rst_busy3", {31'b0, rs2_busy}, 32'd0);
        check("post_rst_wen", {31'b0, wb_wen}, 32'd0);

        // 3: EXU rd=3 and LSU rd=4 both valid for three cycles -> EXU, LSU, EXU
        exu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        check("rr1_exu_ready", {31'b0, exu_ready}, 32'd1);
        check("rr1_lsu_ready", {31'b0, lsu_ready}, 32'd0);
        tick();
        check("rr1_wen", {31'b0, wb_wen}, 32'd1);
        check("rr1_addr", {27'b0, wb_addr}, 32'd3);
        check("rr1_data", wb_data, 32'h33);
        check("rr2_lsu_ready", {31'b0, lsu_ready}, 32'd1);
        check("rr2_exu_ready", {31'b0, exu_ready}, 32'd0);
        tick();
        check("rr2_addr", {27'b0, wb_addr}, 32'd4);
        check("rr2_data", wb_data, 32'h44);
        check("rr3_exu_ready", {31'b0, exu_ready}, 32'd1);
        tick();
        check("rr3_addr", {27'b0, wb_addr}, 32'd3);
        exu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        check("rr_idle_wen", {31'b0, wb_wen}, 32'd0);
        check("rr_idle_addr_hold", {27'b0, wb_addr}, 32'd3);

        // 2: issue rd=5, then EXU writes rd=5
        issue_valid = 1'b1; issue_rd = 5'd5; rs1_addr = 5'd5;
        #1;
        check("iss5_ready", {31'b0, issue_ready}, 32'd1);
        tick();
        issue_valid = 1'b0;
        #1;
        check("iss5_busy", {31'b0, rs1_busy}, 32'd1);
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
        #1;
        check("wb5_exu_ready", {31'b0, exu_ready}, 32'd1);
        tick();
        exu_valid = 1'b0;
        #1;
        check("wb5_wen", {31'b0, wb_wen}, 32'd1);
        check("wb5_addr", {27'b0, wb_addr}, 32'd5);
        check("wb5_data", wb_data, 32'hDEADBEEF);
        check("wb5_busy_n1", {31'b0, rs1_busy}, 32'd1);
        tick();
        check("wb5_busy_n2", {31'b0, rs1_busy}, 32'd0);
        check("wb5_wen_n2", {31'b0, wb_wen}, 32'd0);
        check("wb5_data_hold", wb_data, 32'hDEADBEEF);

        // 4: EXU write to x0 handshakes but never strobes
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'd1; rs2_addr = 5'd0;
        #1;
        check("x0_exu_ready", {31'b0, exu_ready}, 32'd1);
        tick();
        exu_valid = 1'b0;
        #1;
        check("x0_wen", {31'b0, wb_wen}, 32'd0);
        check("x0_rs2_busy", {31'b0, rs2_busy}, 32'd0);
        check("x0_rs1_busy", {31'b0, rs1_busy}, 32'd0);

        // 5: WAW stall on busy x7, released by the committing write; set wins over clear
        issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
        tick();
        check("b7_set", {31'b0, rs1_busy}, 32'd1);
        check("b7_waw_stall", {31'b0, issue_ready}, 32'd0);
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h77;
        tick();
        exu_valid = 1'b0;
        #1;
        check("b7_wen", {31'b0, wb_wen}, 32'd1);
        check("b7_release", {31'b0, issue_ready}, 32'd1);
        check("b7_no_bypass", {31'b0, rs1_busy}, 32'd1);
        tick();
        issue_valid = 1'b0;
        #1;
        check("b7_set_wins", {31'b0, rs1_busy}, 32'd1);
        check("b7_ready_idle", {31'b0, issue_ready}, 32'd0);

        // 6: reset arrives the cycle after a handshake
        issue_valid = 1'b1; issue_rd = 5'd9;
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'hAA; rs2_addr = 5'd9;
        tick();
        issue_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_wen", {31'b0, wb_wen}, 32'd0);
        check("mid_rst_exu_ready", {31'b0, exu_ready}, 32'd0);
        check("mid_rst_rs1_busy", {31'b0, rs1_busy}, 32'd0);
        tick();
        exu_valid = 1'b0;
        check("rst2_wen", {31'b0, wb_wen}, 32'd0);
        check("rst2_addr", {27'b0, wb_addr}, 32'd0);
        check("rst2_data", wb_data, 32'd0);
        rst = 1'b1;
        #1;
        check("rst2_busy7", {31'b0, rs1_busy}, 32'd0);
        check("rst2_busy9", {31'b0, rs2_busy}, 32'd0);
        tick();
        check("rst2_idle_wen", {31'b0, wb_wen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
